// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side signal bundle for ahb_sram_slave.
// master drives the address/data phase, slave returns ready/data/response.
interface ahb_sram_slave_if;
    logic        hsel_i;
    logic [31:0] haddr_i;
    logic [1:0]  htrans_i;
    logic        hwrite_i;
    logic [2:0]  hsize_i;
    logic [2:0]  hburst_i;
    logic [3:0]  hprot_i;
    logic        hmastlock_i;
    logic [31:0] hwdata_i;
    logic        hready_i;
    logic        hreadyout_o;
    logic [31:0] hrdata_o;
    logic [1:0]  hresp_o;

    modport master (
        output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i,
        output hburst_i, hprot_i, hmastlock_i, hwdata_i, hready_i,
        input  hreadyout_o, hrdata_o, hresp_o
    );

    modport slave (
        input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i,
        input  hburst_i, hprot_i, hmastlock_i, hwdata_i, hready_i,
        output hreadyout_o, hrdata_o, hresp_o
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave with configurable wait states.
// Define AHB_SRAM_SLAVE_ERR_EN to enable range/size/alignment ERROR responses.
module ahb_sram_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic            hclk,
    input  logic            hresetn,
    ahb_sram_slave_if.slave s
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [2:0] WS_LOAD =
        (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      r_state;
    state_t      w_nxt;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_write;
    logic [2:0]  r_size;
    logic [31:0] r_mem [MEM_DEPTH];

    logic          w_sample;
    logic          w_accept;
    logic          w_err;
    logic          w_we;
    logic [3:0]    w_mask;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    assign w_sample = s.hsel_i && s.hready_i && s.htrans_i[1];
    assign w_accept = w_sample &&
        (r_state == ST_IDLE || r_state == ST_DATA);

`ifdef AHB_SRAM_SLAVE_ERR_EN
    always_comb begin
        w_err = 1'b0;
        if (|s.haddr_i[31:AW+2])
            w_err = 1'b1;
        if (s.hsize_i > 3'd2)
            w_err = 1'b1;
        if (s.hsize_i == 3'd1 && s.haddr_i[0])
            w_err = 1'b1;
        if (s.hsize_i == 3'd2 && |s.haddr_i[1:0])
            w_err = 1'b1;
    end
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= 32'd0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
        end else begin
            r_state <= w_nxt;
            if (w_accept) begin
                r_addr  <= s.haddr_i;
                r_write <= s.hwrite_i;
                r_size  <= s.hsize_i;
                r_cnt   <= WS_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        w_nxt         = r_state;
        s.hreadyout_o = 1'b1;
        s.hresp_o     = 2'b00;
        unique case (r_state)
            ST_IDLE, ST_DATA: begin
                if (!w_accept)
                    w_nxt = ST_IDLE;
                else if (w_err)
                    w_nxt = ST_ERR1;
                else if (WAIT_STATES > 0)
                    w_nxt = ST_WAIT;
                else
                    w_nxt = ST_DATA;
            end
            ST_WAIT: begin
                s.hreadyout_o = 1'b0;
                if (r_cnt == 3'd0)
                    w_nxt = ST_DATA;
            end
            ST_ERR1: begin
                s.hreadyout_o = 1'b0;
                s.hresp_o     = 2'b01;
                w_nxt         = ST_ERR2;
            end
            ST_ERR2: begin
                s.hresp_o = 2'b01;
                w_nxt     = ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    // Misaligned accesses fall to the enclosing lanes; sizes above word act as word.
    always_comb begin
        w_mask = 4'b1111;
        unique case (1'b1)
            (r_size == 3'd0): w_mask = 4'b0001 << r_addr[1:0];
            (r_size == 3'd1): w_mask = r_addr[1] ? 4'b1100 : 4'b0011;
            default:          w_mask = 4'b1111;
        endcase
    end

    assign w_idx = r_addr[AW+1:2];
    assign w_we  = (r_state == ST_DATA) && r_write;

    always_ff @(posedge hclk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b])
                    r_mem[w_idx][8*b +: 8] <= s.hwdata_i[8*b +: 8];
            end
        end
    end

    assign s.hrdata_o = (r_state == ST_DATA && !r_write) ?
        r_mem[w_idx] : 32'd0;

    assign w_unused = ^{s.hburst_i, s.hprot_i, s.hmastlock_i,
                        s.htrans_i[0], r_addr[31:AW+2]};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait and one two-wait instance.
// Honors AHB_SRAM_SLAVE_ERR_EN to pick the out-of-range expectation.
module tb_ahb_sram_slave;
    logic        hclk;
    logic        hresetn;
    logic        t_hsel;
    logic [31:0] t_haddr;
    logic [1:0]  t_htrans;
    logic        t_hwrite;
    logic [2:0]  t_hsize;
    logic [31:0] t_hwdata;
    int          t_dut;
    int          n_cmp;
    int          n_err;
    logic [31:0] t_wd [4];
    logic [31:0] t_rd [4];
    int          t_nlow [4];
    logic [1:0]  t_resp [4];

    ahb_sram_slave_if if0 ();
    ahb_sram_slave_if if1 ();

    ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .hclk    (hclk),
        .hresetn (hresetn),
        .s       (if0)
    );

    ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(2)) u_dut1 (
        .hclk    (hclk),
        .hresetn (hresetn),
        .s       (if1)
    );

    assign if0.hsel_i      = t_hsel && (t_dut == 0);
    assign if0.haddr_i     = t_haddr;
    assign if0.htrans_i    = t_htrans;
    assign if0.hwrite_i    = t_hwrite;
    assign if0.hsize_i     = t_hsize;
    assign if0.hburst_i    = 3'b011;
    assign if0.hprot_i     = 4'b0011;
    assign if0.hmastlock_i = 1'b0;
    assign if0.hwdata_i    = t_hwdata;
    assign if0.hready_i    = if0.hreadyout_o;

    assign if1.hsel_i      = t_hsel && (t_dut == 1);
    assign if1.haddr_i     = t_haddr;
    assign if1.htrans_i    = t_htrans;
    assign if1.hwrite_i    = t_hwrite;
    assign if1.hsize_i     = t_hsize;
    assign if1.hburst_i    = 3'b011;
    assign if1.hprot_i     = 4'b0011;
    assign if1.hmastlock_i = 1'b0;
    assign if1.hwdata_i    = t_hwdata;
    assign if1.hready_i    = if1.hreadyout_o;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic logic f_rdy(input int d);
        return (d == 0) ? if0.hreadyout_o : if1.hreadyout_o;
    endfunction

    function automatic logic [31:0] f_rd(input int d);
        return (d == 0) ? if0.hrdata_o : if1.hrdata_o;
    endfunction

    function automatic logic [1:0] f_resp(input int d);
        return (d == 0) ? if0.hresp_o : if1.hresp_o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_ph(input int d, input logic [31:0] a,
                           input logic w, input logic [2:0] sz,
                           input logic [1:0] tr);
        t_dut    = d;
        t_hsel   = 1'b1;
        t_haddr  = a;
        t_hwrite = w;
        t_hsize  = sz;
        t_htrans = tr;
    endtask

    task automatic idle_ph();
        t_hsel   = 1'b0;
        t_htrans = 2'b00;
    endtask

    // NONSEQ then SEQ beats; wait cycles per beat are counted, bounded at 20.
    task automatic burst(input int d, input logic w, input logic [31:0] a0,
                         input logic [2:0] sz, input int n);
        int cnt;
        addr_ph(d, a0, w, sz, 2'b10);
        step();
        for (int i = 0; i < n; i++) begin
            t_hwdata = w ? t_wd[i] : 32'h0;
            if (i < n - 1)
                addr_ph(d, a0 + 32'(4 * (i + 1)), w, sz, 2'b11);
            else
                idle_ph();
            cnt = 0;
            while (!f_rdy(d) && cnt < 20) begin
                step();
                cnt++;
            end
            t_nlow[i] = cnt;
            t_rd[i]   = f_rd(d);
            t_resp[i] = f_resp(d);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        t_dut    = 0;
        t_hsel   = 1'b0;
        t_haddr  = 32'h0;
        t_htrans = 2'b00;
        t_hwrite = 1'b0;
        t_hsize  = 3'd2;
        t_hwdata = 32'h0;
        hresetn  = 1'b0;
        #1;
        chk("rst_rdy0", 32'(f_rdy(0)), 32'd1);
        chk("rst_resp0", 32'(f_resp(0)), 32'd0);
        chk("rst_rd0", f_rd(0), 32'd0);
        chk("rst_rdy1", 32'(f_rdy(1)), 32'd1);
        step();
        step();
        hresetn = 1'b1;
        step();

        // write then pipelined read of the same word
        addr_ph(0, 32'h10, 1'b1, 3'd2, 2'b10);
        step();
        chk("wr_data_rdy", 32'(f_rdy(0)), 32'd1);
        t_hwdata = 32'hDEADBEEF;
        addr_ph(0, 32'h10, 1'b0, 3'd2, 2'b10);
        step();
        chk("rd_rdy", 32'(f_rdy(0)), 32'd1);
        chk("rd_data", f_rd(0), 32'hDEADBEEF);
        chk("rd_resp", 32'(f_resp(0)), 32'd0);
        idle_ph();
        step();
        chk("idle_rd_zero", f_rd(0), 32'd0);

        // BUSY and deselected NONSEQ must not touch memory
        addr_ph(0, 32'h10, 1'b1, 3'd2, 2'b01);
        step();
        t_hwdata = 32'h0;
        chk("busy_rdy", 32'(f_rdy(0)), 32'd1);
        chk("busy_resp", 32'(f_resp(0)), 32'd0);
        addr_ph(0, 32'h10, 1'b1, 3'd2, 2'b10);
        t_hsel = 1'b0;
        step();
        step();
        burst(0, 1'b0, 32'h10, 3'd2, 1);
        chk("nosel_keep", t_rd[0], 32'hDEADBEEF);

        // byte and halfword lane writes
        t_wd[0] = 32'h11223344;
        burst(0, 1'b1, 32'h20, 3'd2, 1);
        t_wd[0] = 32'h00AA0000;
        burst(0, 1'b1, 32'h22, 3'd0, 1);
        burst(0, 1'b0, 32'h20, 3'd2, 1);
        chk("byte_lane", t_rd[0], 32'h11AA3344);
        t_wd[0] = 32'hCAFEBABE;
        burst(0, 1'b1, 32'h24, 3'd2, 1);
        t_wd[0] = 32'h12340000;
        burst(0, 1'b1, 32'h26, 3'd1, 1);
        burst(0, 1'b0, 32'h24, 3'd2, 1);
        chk("half_lane", t_rd[0], 32'h1234BABE);

`ifdef AHB_SRAM_SLAVE_ERR_EN
        t_wd[0] = 32'h0BADF00D;
        burst(0, 1'b1, 32'h0, 3'd2, 1);
        addr_ph(0, 32'h400, 1'b1, 3'd2, 2'b10);
        step();
        t_hwdata = 32'hFFFFFFFF;
        idle_ph();
        chk("err1_rdy", 32'(f_rdy(0)), 32'd0);
        chk("err1_resp", 32'(f_resp(0)), 32'd1);
        step();
        chk("err2_rdy", 32'(f_rdy(0)), 32'd1);
        chk("err2_resp", 32'(f_resp(0)), 32'd1);
        step();
        chk("err_done_resp", 32'(f_resp(0)), 32'd0);
        burst(0, 1'b0, 32'h0, 3'd2, 1);
        chk("err_no_write", t_rd[0], 32'h0BADF00D);
`else
        t_wd[0] = 32'h600DCAFE;
        burst(0, 1'b1, 32'h400, 3'd2, 1);
        chk("wrap_resp", 32'(t_resp[0]), 32'd0);
        burst(0, 1'b0, 32'h0, 3'd2, 1);
        chk("wrap_word0", t_rd[0], 32'h600DCAFE);
        t_wd[0] = 32'h77770000;
        burst(0, 1'b1, 32'h23, 3'd1, 1);
        burst(0, 1'b0, 32'h20, 3'd2, 1);
        chk("misalign_half", t_rd[0], 32'h77773344);
`endif

        // two wait states per beat on an INCR4
        for (int i = 0; i < 4; i++)
            t_wd[i] = 32'(i + 1);
        burst(1, 1'b1, 32'h40, 3'd2, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("ws_wr_low%0d", i), 32'(t_nlow[i]), 32'd2);
        burst(1, 1'b0, 32'h40, 3'd2, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ws_rd%0d", i), t_rd[i], 32'(i + 1));
            chk($sformatf("ws_rd_low%0d", i), 32'(t_nlow[i]), 32'd2);
        end

        // reset during a wait state aborts the write
        t_wd[0] = 32'h5;
        burst(1, 1'b1, 32'h30, 3'd2, 1);
        addr_ph(1, 32'h30, 1'b1, 3'd2, 2'b10);
        step();
        t_hwdata = 32'hFFFFFFFF;
        idle_ph();
        chk("mid_wait_rdy", 32'(f_rdy(1)), 32'd0);
        hresetn = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(f_rdy(1)), 32'd1);
        chk("mid_rst_resp", 32'(f_resp(1)), 32'd0);
        chk("mid_rst_rd", f_rd(1), 32'd0);
        step();
        step();
        hresetn = 1'b1;
        burst(1, 1'b0, 32'h30, 3'd2, 1);
        chk("post_rst_rd", t_rd[0], 32'h5);
        chk("post_rst_low", 32'(t_nlow[0]), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, giving the number of 32-bit words in the memory (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT_STATES, default 0, giving the number of extra data-phase cycles per beat (0..7).
REQ-003 SHALL have port hclk, input, 1 bit, AHB clock; all state changes on its rising edge.
REQ-004 SHALL have port hresetn, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have the following AHB input ports:
- hsel_i, 1 bit, slave select.
- haddr_i, 32 bits, byte address.
- htrans_i, 2 bits, transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite_i, 1 bit, 1 = write.
- hsize_i, 3 bits, transfer size: 000 byte, 001 halfword, 010 word.
- hburst_i, 3 bits, burst type; hprot_i, 4 bits; hmastlock_i, 1 bit. These three are accepted but ignored.
- hwdata_i, 32 bits, write data.
- hready_i, 1 bit, bus-level ready.
REQ-006 SHALL have the following output ports:
- hreadyout_o, 1 bit, slave ready.
- hrdata_o, 32 bits, read data.
- hresp_o, 2 bits, response: 00 OKAY, 01 ERROR.

Function
REQ-007 SHALL sample an address phase only when hsel_i=1, hready_i=1 and htrans_i is NONSEQ or SEQ.
- On a sample, it SHALL register haddr_i, hwrite_i and hsize_i.
REQ-008 SHALL treat IDLE, BUSY or hsel_i=0 as no transfer: no memory access, and hreadyout_o=1 with hresp_o=00 in the following cycle.
REQ-009 SHALL implement states ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1 and ST_ERR2 with these transitions:
- A valid sample goes to ST_WAIT if WAIT_STATES>0, otherwise to ST_DATA.
- ST_WAIT goes to ST_DATA after WAIT_STATES cycles, counted by a 3-bit down-counter.
- ST_DATA goes to ST_WAIT, ST_DATA or ST_IDLE depending on whether a new address phase is sampled in the same cycle.
REQ-010 SHALL drive hreadyout_o=0 in ST_WAIT and hreadyout_o=1 in ST_DATA and ST_IDLE; wait states apply to every beat, including SEQ beats.
REQ-011 SHALL accept a new address phase in the same cycle as the final (hreadyout_o=1) data-phase cycle of the previous transfer, giving fully pipelined back-to-back beats.
REQ-012 SHALL commit a write in the ST_DATA cycle, updating only the byte lanes selected by hsize and haddr[1:0]:
- byte: lane haddr[1:0].
- halfword: lanes {haddr[1],0} and {haddr[1],1}.
- word: all four lanes.
REQ-013 SHALL take hwdata_i already lane-aligned by the master and SHALL NOT shift it.
REQ-014 SHALL drive hrdata_o with the full 32-bit word mem[haddr_r[log2(MEM_DEPTH)+1:2]] during ST_DATA of a read, and 0 otherwise; the master performs lane extraction.
REQ-015 SHALL return the just-written value when a read immediately follows a write to the same word, because the write commits before the read's data phase.
REQ-016 SHALL index the memory by haddr_r[log2(MEM_DEPTH)+1:2]; higher address bits are handled per REQ-021/REQ-022.
REQ-017 SHALL drive hresp_o=00 in every state except ST_ERR1 and ST_ERR2.
REQ-018 SHALL keep the memory array un-reset; its contents after reset are undefined.

Reset
REQ-019 SHALL, while hresetn=0, force:
- state ST_IDLE, wait counter 0 and all registered address-phase fields 0.
- hreadyout_o=1, hresp_o=00, hrdata_o=0.
REQ-020 SHALL abort any in-flight transfer when reset is asserted mid-operation, with no memory write, and SHALL accept a fresh NONSEQ in the first cycle after deassertion.

Configuration
REQ-021 SHALL, when macro AHB_SRAM_SLAVE_ERR_EN is defined, flag an error if any of the following holds at address-phase sample:
- haddr_i >= 4*MEM_DEPTH.
- hsize_i > 010.
- haddr_i is misaligned to hsize_i.
An errored transfer SHALL skip the write and give the two-cycle response: ST_ERR1 (hreadyout_o=0, hresp_o=01), then ST_ERR2 (hreadyout_o=1, hresp_o=01), then ST_IDLE, ignoring any address phase presented during ST_ERR2.
REQ-022 SHALL, when AHB_SRAM_SLAVE_ERR_EN is undefined, never enter ST_ERR1 or ST_ERR2 and always respond OKAY:
- Out-of-range addresses wrap modulo 4*MEM_DEPTH.
- Misaligned addresses are aligned down to the size.
- hsize_i > 010 is treated as a word access.

Verification
REQ-023 SHALL cover: WAIT_STATES=0, word write 0xDEADBEEF to 0x10, then read 0x10 -> hreadyout_o stays 1, hrdata_o=0xDEADBEEF in the read data phase, hresp_o=00.
REQ-024 SHALL cover: word 0x11223344 at 0x20, then byte write hwdata_i=0x00AA0000 at 0x22, then word read 0x20 -> 0x11AA3344.
REQ-025 SHALL cover: WAIT_STATES=2, INCR4 write of 1,2,3,4 at 0x40 (NONSEQ then 3 SEQ) -> each beat shows exactly 2 cycles of hreadyout_o=0; a read-back of 0x40..0x4C returns 1,2,3,4.
REQ-026 SHALL cover: with AHB_SRAM_SLAVE_ERR_EN and MEM_DEPTH=256, write to 0x400 -> hresp_o=01 for 2 cycles, with hreadyout_o going 0 then 1, and no memory change; without the macro, the same write lands at word 0.
REQ-027 SHALL cover: hresetn pulsed low during ST_WAIT of a write to 0x30 (previously 0x5) -> outputs return to reset values, and a subsequent read of 0x30 returns 0x5.
